pipe_cache: RTL and testbench
=============================

# pipe_cache

Parametrised direct-mapped, write-through, no-write-allocate cache that sits between one memory port of the pipelined CPU (instruction or data side) and the backing memory. Read hits return data in the same cycle. Misses stall the pipeline through `c_ready` while a line fill runs over a word-serial memory handshake. Two instances are used in the CPU top, one per port, with hit/access counters exported for performance reporting.

## Interface
Parameters:
- `WORD_SIZE`, 16: data and address width in bits; addresses are word addresses.
- `LINE_WORDS`, 4: words per line; power of 2, minimum 2.
- `NUM_LINES`, 4: number of lines; power of 2, minimum 2.
- `CNT_WIDTH`, 16: width of the performance counters.

Ports:
- `Clk` input, 1: single clock; all state changes on the rising edge.
- `Reset_N` input, 1: asynchronous, active-low reset.
- `c_readM` input, 1: CPU read request.
- `c_writeM` input, 1: CPU write request.
- `c_address` input, WORD_SIZE: CPU word address.
- `c_wdata` input, WORD_SIZE: CPU write data.
- `c_rdata` output, WORD_SIZE: read data; valid when `c_ready`=1 and `c_readM`=1.
- `c_ready` output, 1: access completes this cycle. When low, the CPU stalls.
- `m_readM` output, 1: memory read request.
- `m_writeM` output, 1: memory write request.
- `m_address` output, WORD_SIZE: memory word address.
- `m_wdata` output, WORD_SIZE: memory write data.
- `m_rdata` input, WORD_SIZE: memory read data; valid when `m_ready`=1.
- `m_ready` input, 1: one-cycle pulse marking completion of the current memory word.
- `num_access` output, CNT_WIDTH: number of completed CPU accesses.
- `num_hit` output, CNT_WIDTH: number of read accesses that hit on first presentation.

## Operation
- Address split: offset = low log2(LINE_WORDS) bits; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Per-line state: `valid` bit, tag, and LINE_WORDS data words.
- FSM states:
  - IDLE: accepting requests.
  - FILL: line refill in progress; holds a word counter `fcnt`.
  - WRITE: memory write in progress.
- **IDLE, read hit** (valid and tag match):
  - `c_ready`=1 combinationally; `c_rdata` = cached word.
  - No memory activity.
- **IDLE, read miss:**
  - `c_ready`=0.
  - Next edge: enter FILL with `fcnt`=0 and clear that line's `valid`.
- **FILL:**
  - `m_readM`=1; `m_address` = {tag, index, `fcnt`}.
  - On each `m_ready`: store `m_rdata` into word `fcnt`, then increment `fcnt`.
  - On the `m_ready` for word LINE_WORDS-1: write the tag, set `valid`, return to IDLE.
  - The request is then a hit in the following cycle.
- **IDLE, write:**
  - `c_ready`=0.
  - Next edge: enter WRITE.
- **WRITE:**
  - `m_writeM`=1; `m_address` = `c_address`; `m_wdata` = `c_wdata`.
  - On `m_ready`: `c_ready`=1 that cycle, return to IDLE.
  - If the line is valid with a matching tag, update the cached word on the same edge. A miss does not allocate.
- `c_readM` and `c_writeM` both high is illegal; the write takes priority.
- The CPU holds its request signals stable while `c_ready`=0.
- Counters:
  - `num_access` increments on every cycle with `c_ready`=1 and a request present.
  - `num_hit` increments only for read hits seen in IDLE that were not preceded by a fill for the same request.
  - Both saturate at all-ones; they do not wrap.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; all `valid` bits 0.
  - `m_readM`=0, `m_writeM`=0; `m_address`=0, `m_wdata`=0.
  - Counters 0.
  - `c_ready`=0 unless a hit is possible, which cannot occur because all lines are invalid.
- Reset asserted during FILL or WRITE aborts the operation. The partially filled line stays invalid.
- Read hit latency: 0 cycles (same cycle).
- Read miss latency: 1 cycle plus the sum of the LINE_WORDS memory word latencies plus 1 cycle. With a 2-cycle memory and LINE_WORDS=4, that is 10 cycles.
- Write latency: 1 cycle plus the memory latency, for hits and misses alike.
- `m_readM` and `m_writeM` are never high together, and are never high in IDLE.
- A `m_ready` that arrives in IDLE is ignored.

## Structure
- Shared package/include holds:
  - FSM state encodings (`CS_IDLE`, `CS_FILL`, `CS_WRITE`).
  - Width derivation (log2) macros.
- One natural sub-module, `cache_perf_counter`: saturating CNT_WIDTH counter with enable. Instantiate it twice.
- Line storage is register arrays inside `pipe_cache`.

## Test plan
All scenarios use the defaults and a memory model with 2-cycle latency where mem[a] = a ^ 16'hA5A5.
- Cold read of 0x0010 -> 10 cycles of `c_ready`=0; `m_address` steps 0x0010..0x0013; then `c_rdata`=0xA5B5; `num_hit`=0, `num_access`=1.
- Read 0x0011 right after the fill -> same-cycle `c_ready`=1, `c_rdata`=0xA5B4; `num_hit`=1.
- Write 0x1234 to 0x0012 (hit) -> `m_writeM` for 2 cycles then `c_ready`; subsequent read of 0x0012 returns 0x1234 with no memory read.
- Write to 0x0050 (miss, index 0) -> memory write only; a following read of 0x0050 misses and fills from memory.
- Conflict: read 0x0010, then 0x0050, then 0x0010 -> three fills; `num_hit` unchanged.
- Assert `Reset_N`=0 in the middle of the fill of 0x0020 -> `m_readM` drops immediately; after release, reading 0x0020 performs a full fresh fill.

Source files
------------

// File: rtl/pipe_cache_pkg.sv
// Shared definitions for the pipe_cache block: controller state encoding
// and the width-derivation helper used to split addresses.
package pipe_cache_pkg;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_FILL  = 2'd1,
    CS_WRITE = 2'd2
  } cache_state_t;

  // Number of address bits needed to select one of 'value' entries.
  function automatic int log2_f(input int value);
    return $clog2(value);
  endfunction

endpackage

// File: rtl/pipe_cache_if.sv
// CPU-side and memory-side handshake bundle of one pipe_cache instance.
// The slave modport is the cache; the master modport is the CPU/memory environment.
interface pipe_cache_if #(
  parameter int WORD_SIZE = 16
);
  logic                 c_readM;
  logic                 c_writeM;
  logic [WORD_SIZE-1:0] c_address;
  logic [WORD_SIZE-1:0] c_wdata;
  logic [WORD_SIZE-1:0] c_rdata;
  logic                 c_ready;
  logic                 m_readM;
  logic                 m_writeM;
  logic [WORD_SIZE-1:0] m_address;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;
  logic                 m_ready;

  modport slave (
    input  c_readM, c_writeM, c_address, c_wdata, m_rdata, m_ready,
    output c_rdata, c_ready, m_readM, m_writeM, m_address, m_wdata
  );

  modport master (
    output c_readM, c_writeM, c_address, c_wdata, m_rdata, m_ready,
    input  c_rdata, c_ready, m_readM, m_writeM, m_address, m_wdata
  );
endinterface

// File: rtl/pipe_cache_perf_counter.sv
// Saturating performance counter: counts enabled cycles and sticks at all-ones.
module cache_perf_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  // Advance on enable unless already saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_cache.sv
// Direct-mapped, write-through, no-write-allocate cache between one CPU port
// and a word-serial backing memory. Read hits complete in the same cycle;
// misses refill the whole line word by word while c_ready holds the CPU.
module pipe_cache
  import pipe_cache_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  pipe_cache_if.slave          bus,
  output logic [CNT_WIDTH-1:0] num_access,
  output logic [CNT_WIDTH-1:0] num_hit
);

  localparam int OFF_W = log2_f(LINE_WORDS);
  localparam int IDX_W = log2_f(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  cache_state_t         state_r, state_nxt_s;
  logic [OFF_W-1:0]     fcnt_r;
  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_r [NUM_LINES][LINE_WORDS];
  logic                 fill_done_r;

  logic [OFF_W-1:0]     off_s;
  logic [IDX_W-1:0]     idx_s;
  logic [TAG_W-1:0]     tag_s;
  logic                 hit_s;
  logic                 miss_start_s, fill_word_s, fill_last_s, write_done_s;
  logic                 access_done_s, first_hit_s;
  logic                 c_ready_s, m_readM_s, m_writeM_s;
  logic [WORD_SIZE-1:0] c_rdata_s, m_address_s, m_wdata_s;

  assign off_s = bus.c_address[OFF_W-1:0];
  assign idx_s = bus.c_address[OFF_W +: IDX_W];
  assign tag_s = bus.c_address[WORD_SIZE-1 -: TAG_W];
  assign hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);

  // Writes take priority when both request lines are (illegally) high
  assign miss_start_s  = (state_r == CS_IDLE) && !bus.c_writeM && bus.c_readM && !hit_s;
  assign fill_word_s   = (state_r == CS_FILL) && bus.m_ready;
  assign fill_last_s   = fill_word_s && (fcnt_r == OFF_W'(LINE_WORDS - 1));
  assign write_done_s  = (state_r == CS_WRITE) && bus.m_ready;
  assign access_done_s = c_ready_s && (bus.c_readM || bus.c_writeM);
  // A hit that follows this request's own refill is not a first-presentation hit
  assign first_hit_s   = (state_r == CS_IDLE) && !bus.c_writeM && bus.c_readM && hit_s && !fill_done_r;

  // Next-state and handshake outputs; memory side is quiet in IDLE
  always_comb begin
    state_nxt_s = state_r;
    c_ready_s   = 1'b0;
    c_rdata_s   = '0;
    m_readM_s   = 1'b0;
    m_writeM_s  = 1'b0;
    m_address_s = '0;
    m_wdata_s   = '0;
    case (state_r)
      CS_IDLE: begin
        if (bus.c_writeM) begin
          state_nxt_s = CS_WRITE;
        end else if (bus.c_readM && hit_s) begin
          c_ready_s = 1'b1;
          c_rdata_s = data_r[idx_s][off_s];
        end else if (bus.c_readM) begin
          state_nxt_s = CS_FILL;
        end else begin
          state_nxt_s = CS_IDLE;
        end
      end
      CS_FILL: begin
        m_readM_s   = 1'b1;
        m_address_s = {tag_s, idx_s, fcnt_r};
        if (fill_last_s) begin
          state_nxt_s = CS_IDLE;
        end else begin
          state_nxt_s = CS_FILL;
        end
      end
      CS_WRITE: begin
        m_writeM_s  = 1'b1;
        m_address_s = bus.c_address;
        m_wdata_s   = bus.c_wdata;
        if (bus.m_ready) begin
          c_ready_s   = 1'b1;
          state_nxt_s = CS_IDLE;
        end else begin
          state_nxt_s = CS_WRITE;
        end
      end
      default: begin
        state_nxt_s = CS_IDLE;
      end
    endcase
  end

  assign bus.c_ready   = c_ready_s;
  assign bus.c_rdata   = c_rdata_s;
  assign bus.m_readM   = m_readM_s;
  assign bus.m_writeM  = m_writeM_s;
  assign bus.m_address = m_address_s;
  assign bus.m_wdata   = m_wdata_s;

  // Controller state register
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_r <= CS_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Refill word counter: advances per returned word, parked at zero in IDLE
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      fcnt_r <= '0;
    end else if (fill_word_s) begin
      fcnt_r <= fcnt_r + OFF_W'(1);
    end else if (state_r == CS_IDLE) begin
      fcnt_r <= '0;
    end
  end

  // Line storage: invalidate on miss, refill word by word, write-through update on hit
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      valid_r <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_r[i] <= '0;
        for (int j = 0; j < LINE_WORDS; j++) begin
          data_r[i][j] <= '0;
        end
      end
    end else if (miss_start_s) begin
      valid_r[idx_s] <= 1'b0;
    end else if (fill_word_s) begin
      data_r[idx_s][fcnt_r] <= bus.m_rdata;
      if (fill_last_s) begin
        tag_r[idx_s]   <= tag_s;
        valid_r[idx_s] <= 1'b1;
      end
    end else if (write_done_s && hit_s) begin
      data_r[idx_s][off_s] <= bus.c_wdata;
    end
  end

  // Remember that the pending request was satisfied by a refill
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      fill_done_r <= 1'b0;
    end else if (fill_last_s) begin
      fill_done_r <= 1'b1;
    end else if (access_done_s) begin
      fill_done_r <= 1'b0;
    end
  end

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_access_cnt (
    .clk   (Clk),
    .rst_n (Reset_N),
    .en    (access_done_s),
    .count (num_access)
  );

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (Clk),
    .rst_n (Reset_N),
    .en    (first_hit_s),
    .count (num_hit)
  );

endmodule

// File: tb/tb_pipe_cache.sv
// Randomised self-checking bench for pipe_cache with a 2-cycle word memory.
module tb_pipe_cache;

  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_cache_if #(.WORD_SIZE(16)) bus ();
  logic [15:0] num_access, num_hit;

  pipe_cache #(.WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(4), .CNT_WIDTH(16)) dut (
    .Clk        (clk),
    .Reset_N    (rst_n),
    .bus        (bus),
    .num_access (num_access),
    .num_hit    (num_hit)
  );

  // Narrow counter instance to exercise saturation in a few cycles
  logic       sat_en = 1'b0;
  logic [2:0] sat_count;
  cache_perf_counter #(.CNT_WIDTH(3)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sat_en),
    .count (sat_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [15:0] mem_store [int];
  logic [15:0] rd_log [$];
  int          wr_cnt = 0;
  int          wcnt = 0;
  bit          stray_req = 1'b0;

  function automatic logic [15:0] env_rd(input logic [15:0] a);
    if (mem_store.exists(int'(a))) return mem_store[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  // Memory answers each word on the MEM_LAT-th cycle it is requested
  always @(posedge clk) begin
    #1;
    if (bus.m_readM || bus.m_writeM) begin
      if (bus.m_ready) begin
        bus.m_ready = 1'b0;
        wcnt = 0;
      end
      wcnt++;
      if (wcnt == MEM_LAT) begin
        bus.m_ready = 1'b1;
        if (bus.m_readM) begin
          bus.m_rdata = env_rd(bus.m_address);
          rd_log.push_back(bus.m_address);
        end else begin
          mem_store[int'(bus.m_address)] = bus.m_wdata;
          wr_cnt++;
        end
      end
    end else if (stray_req) begin
      bus.m_ready = 1'b1;
      bus.m_rdata = 16'hDEAD;
      stray_req = 1'b0;
      wcnt = 0;
    end else begin
      bus.m_ready = 1'b0;
      wcnt = 0;
    end
  end

  // ---------------- behavioural model ----------------
  bit          mv [4];
  logic [11:0] mt [4];
  logic [15:0] md [4][4];
  logic [15:0] exp_mem [int];
  logic [15:0] exp_access = 16'd0;
  logic [15:0] exp_hit = 16'd0;

  function automatic logic [15:0] model_mem(input logic [15:0] a);
    if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    exp_access = 16'd0;
    exp_hit = 16'd0;
  endtask

  // ---------------- compare process ----------------
  bit          acc_active = 1'b0;
  bit          exp_is_read = 1'b0;
  logic [15:0] exp_rdata = 16'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_rw_exclusive", {31'd0, bus.m_readM & bus.m_writeM}, 32'd0);
      if (!acc_active) begin
        chk("idle_c_ready", {31'd0, bus.c_ready}, 32'd0);
      end else if (bus.c_ready && exp_is_read) begin
        chk("c_rdata", {16'd0, bus.c_rdata}, {16'd0, exp_rdata});
      end
    end
  end

  // One CPU access: predict outcome from the model, drive it, check the result
  task automatic access(input bit is_wr, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd);
    logic [1:0]  idx;
    logic [1:0]  off;
    logic [11:0] tag;
    bit          hit;
    int          exp_cyc;
    int          exp_wr;
    int          cyc;
    int          wr0;
    logic [15:0] exp_reads [$];
    idx = addr[3:2];
    off = addr[1:0];
    tag = addr[15:4];
    hit = mv[idx] && (mt[idx] == tag);
    exp_wr = 0;
    if (is_wr) begin
      exp_cyc = 1 + MEM_LAT;
      exp_wr = 1;
      exp_mem[int'(addr)] = wd;
      if (hit) md[idx][off] = wd;
    end else if (hit) begin
      exp_cyc = 1;
      exp_hit = sat_inc(exp_hit);
    end else begin
      exp_cyc = 2 + 4 * MEM_LAT;
      for (int w = 0; w < 4; w++) begin
        logic [15:0] a;
        a = {tag, idx, 2'(w)};
        md[idx][w] = model_mem(a);
        exp_reads.push_back(a);
      end
      mv[idx] = 1'b1;
      mt[idx] = tag;
    end
    exp_access = sat_inc(exp_access);
    exp_rdata = md[idx][off];
    exp_is_read = !is_wr;
    rd_log.delete();
    wr0 = wr_cnt;
    bus.c_readM = !is_wr;
    bus.c_writeM = is_wr;
    bus.c_address = addr;
    bus.c_wdata = wd;
    acc_active = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.c_ready && cyc < 60);
    rd = bus.c_rdata;
    chk("latency", cyc, exp_cyc);
    @(posedge clk);
    #1;
    acc_active = 1'b0;
    bus.c_readM = 1'b0;
    bus.c_writeM = 1'b0;
    chk("mem_read_count", rd_log.size(), exp_reads.size());
    for (int i = 0; i < rd_log.size() && i < exp_reads.size(); i++)
      chk("mem_read_addr", {16'd0, rd_log[i]}, {16'd0, exp_reads[i]});
    chk("mem_write_count", wr_cnt - wr0, exp_wr);
    chk("num_access", {16'd0, num_access}, {16'd0, exp_access});
    chk("num_hit", {16'd0, num_hit}, {16'd0, exp_hit});
  endtask

  logic [15:0] rd;

  initial begin
    bus.c_readM = 1'b1;
    bus.c_writeM = 1'b0;
    bus.c_address = 16'h0010;
    bus.c_wdata = 16'h0000;
    bus.m_ready = 1'b0;
    bus.m_rdata = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c_ready", {31'd0, bus.c_ready}, 32'd0);
    chk("rst_m_readM", {31'd0, bus.m_readM}, 32'd0);
    chk("rst_m_writeM", {31'd0, bus.m_writeM}, 32'd0);
    chk("rst_m_address", {16'd0, bus.m_address}, 32'd0);
    chk("rst_m_wdata", {16'd0, bus.m_wdata}, 32'd0);
    chk("rst_num_access", {16'd0, num_access}, 32'd0);
    chk("rst_num_hit", {16'd0, num_hit}, 32'd0);
    bus.c_readM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed scenarios with hand-computed results
    access(1'b0, 16'h0010, 16'h0000, rd);
    chk("cold_rd_data", {16'd0, rd}, 32'h0000A5B5);
    chk("cold_rd_hits", {16'd0, num_hit}, 32'd0);
    access(1'b0, 16'h0011, 16'h0000, rd);
    chk("hit_rd_data", {16'd0, rd}, 32'h0000A5B4);
    chk("hit_rd_hits", {16'd0, num_hit}, 32'd1);
    access(1'b1, 16'h0012, 16'h1234, rd);
    access(1'b0, 16'h0012, 16'h0000, rd);
    chk("wr_hit_rd_data", {16'd0, rd}, 32'h00001234);
    access(1'b1, 16'h0050, 16'hBEEF, rd);
    access(1'b0, 16'h0050, 16'h0000, rd);
    chk("wr_miss_rd_data", {16'd0, rd}, 32'h0000BEEF);
    access(1'b0, 16'h0010, 16'h0000, rd);
    access(1'b0, 16'h0050, 16'h0000, rd);
    access(1'b0, 16'h0010, 16'h0000, rd);
    chk("conflict_hits", {16'd0, num_hit}, 32'd2);
    chk("conflict_access", {16'd0, num_access}, 32'd9);

    // Stray m_ready in IDLE must be ignored
    stray_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    access(1'b0, 16'h0011, 16'h0000, rd);
    chk("after_stray_data", {16'd0, rd}, 32'h0000A5B4);

    // Reset in the middle of a refill
    exp_is_read = 1'b1;
    exp_rdata = 16'hA585;
    bus.c_address = 16'h0020;
    bus.c_readM = 1'b1;
    acc_active = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_fill_m_readM", {31'd0, bus.m_readM}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_m_readM", {31'd0, bus.m_readM}, 32'd0);
    chk("abort_m_address", {16'd0, bus.m_address}, 32'd0);
    chk("abort_num_access", {16'd0, num_access}, 32'd0);
    model_reset();
    bus.c_readM = 1'b0;
    acc_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, 16'h0020, 16'h0000, rd);
    chk("refill_data", {16'd0, rd}, 32'h0000A585);
    access(1'b0, 16'h0010, 16'h0000, rd);

    // Random traffic over a small address window to force conflicts
    repeat (300) begin
      bit          w;
      logic [15:0] a;
      w = ($urandom % 4) == 0;
      a = 16'($urandom_range(0, 127));
      access(w, a, 16'($urandom), rd);
      repeat ($urandom % 2) @(posedge clk);
      #1;
    end

    // Saturation of a narrow counter
    @(posedge clk);
    #1;
    sat_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("sat_count_5", {29'd0, sat_count}, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_count_hold", {29'd0, sat_count}, 32'd7);
    sat_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
